pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencer for the MyProc2 five-stage core: it generates the stall, flush and bubble controls that gate the IF, ID and EXE stages. It detects RAW hazards between the instruction in ID and the writers in EXE/MEM, and freezes the pipe while memory is busy. It runs the post-branch flush sequence after the EXE stage reports `IsBranchTaken`, and latches the halted state on `HALT`. It sits beside the datapath and drives the `IsStall` input of the EXE stage directly.

## Interface
- `FLUSH_CYCLES`, 2: number of cycles FlushIF/FlushID stay high after a taken branch (1..7).
- `CNT_W`, 32: width of the stall-cycle counter.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `ID_IR` in `WIDTH`: instruction in ID.
- `EXE_IR` in `WIDTH`: instruction entering EXE (the IR_in of the EXE stage).
- `MEM_IR` in `WIDTH`: instruction in MEM.
- `IsBranchTaken` in 1: registered branch/jump-taken flag from EXE.
- `MemBusy` in 1: data memory not ready this cycle.
- `StallIF` out 1: hold PC and IF/ID.
- `StallID` out 1: hold the ID stage.
- `IsStall` out 1: hold the EXE stage (EXE registers keep their values).
- `BubbleEXE` out 1: the ID→EXE register loads `NOP` instead of the ID instruction.
- `FlushIF` out 1: the IF/ID register loads `NOP`.
- `FlushID` out 1: the ID→EXE register loads `NOP`.
- `Halted` out 1: core halted; sticky until `rst`.
- `StallCount` out `CNT_W`: saturating count of cycles with `StallIF`=1.

## Operation
- Field decode follows `ISA.v` opcodes, with `OpCode`=IR[31:26], rs=IR[25:21], rt=IR[20:16], rd=IR[15:11].
- Destination register by opcode:
  - rd for ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLLV, SRLV, JALR.
  - rt for ADDI, ANDI, ORI, LUI, LW, LH, LD.
  - 31 for JAL.
  - No destination for all other opcodes.
- Sources:
  - rs for every opcode except LUI, J, JAL, NOP, HALT.
  - rt additionally for the R-type ALU ops and SW, SH, SD.
- Register 0 never creates a hazard. The datapath has no forwarding.
- Hazard: a valid source of ID_IR equals a nonzero destination of EXE_IR or MEM_IR.
- FSM states:
  - RUN, FLUSH and MEMWAIT are entered at the clock edge by the transitions below.
  - HALTED is entered at the clock edge after `HALT` is seen.
  - Evaluation priority each cycle: rst > HALTED > MemBusy > IsBranchTaken/FLUSH > hazard > RUN.
- RUN:
  - On hazard: StallIF=StallID=BubbleEXE=1 combinationally. Repeat each cycle until the hazard clears.
  - IsBranchTaken=1: load the flush counter with FLUSH_CYCLES and go to FLUSH. FlushIF=FlushID=1 in this same cycle.
  - EXE_IR opcode = HALT: go to HALTED.
- FLUSH:
  - FlushIF=FlushID=1; the counter decrements each cycle.
  - When the counter reaches 1, return to RUN on the next edge.
  - The hazard check is suppressed, because the flushed ID holds garbage.
  - A new IsBranchTaken reloads the counter.
- MEMWAIT:
  - Entered from any state except HALTED when MemBusy=1.
  - All of StallIF, StallID and IsStall are 1; the flush counter is frozen.
  - On MemBusy=0, return to the saved state (RUN or FLUSH) on the next edge.
- HALTED: StallIF=StallID=IsStall=1 and Halted=1, held until rst. All other inputs are ignored.
- StallCount increments on every cycle with StallIF=1 and rst=0, and saturates at all-ones.

## Timing
- Reset:
  - While rst=1: StallIF=StallID=IsStall=BubbleEXE=0, FlushIF=FlushID=1, Halted=0.
  - At the first edge with rst=1: state=RUN, counter=0, StallCount=0.
  - rst mid-FLUSH, mid-MEMWAIT or in HALTED returns the block to RUN at that edge.
- Control outputs are combinational from registered state plus current inputs, with zero latency. Halted and StallCount are registered.
- Load-use (LW in EXE, dependent in ID):
  - 1 stall cycle for the EXE match.
  - 1 further cycle while the LW sits in MEM.
  - Total of 2 bubbles.
- Branch penalty: FLUSH_CYCLES cycles of flush, starting in the cycle IsBranchTaken is high.
- Simultaneous events:
  - MemBusy and IsBranchTaken: MEMWAIT wins, the branch is saved, and FLUSH starts on the cycle MemBusy drops.
  - HALT in EXE and IsBranchTaken: the branch is ignored and the block enters HALTED.

## Test plan
- Reset: hold rst 2 cycles → FlushIF=FlushID=1, all stalls 0, StallCount=0. After release, with independent ADDs, zero stalls.
- Hazards:
  - ADD r3 in EXE with SUB r4←r3,r5 in ID → StallIF=BubbleEXE=1 for 2 cycles (EXE then MEM), then 0.
  - A destination of r0 never stalls.
- Branch: BEQ taken, IsBranchTaken pulse 1 cycle, FLUSH_CYCLES=2 → FlushIF/FlushID high exactly 2 cycles. A second pulse on cycle 2 extends the flush to 3 cycles.
- MemBusy:
  - MemBusy high 3 cycles during FLUSH (counter=1) → IsStall=1 for 3 cycles, then 1 more flush cycle.
  - StallCount increases by 3.
- HALT in EXE → Halted=1 on the next edge and all stalls held for ≥10 cycles. rst → RUN, Halted=0.
- StallCount saturation: CNT_W=4, 20 stall cycles → StallCount=15.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_if
// Purpose  : Bundle of signals between the MyProc2 datapath and the pipeline
//            sequencer (pipe_ctrl).
//            Datapath -> sequencer: ID_IR, EXE_IR, MEM_IR, IsBranchTaken, MemBusy
//            Sequencer -> datapath: StallIF, StallID, IsStall, BubbleEXE,
//                                   FlushIF, FlushID, Halted, StallCount
//            master modport = datapath side, slave modport = pipe_ctrl side.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
);
  logic [WIDTH-1:0] ID_IR;
  logic [WIDTH-1:0] EXE_IR;
  logic [WIDTH-1:0] MEM_IR;
  logic             IsBranchTaken;
  logic             MemBusy;
  logic             StallIF;
  logic             StallID;
  logic             IsStall;
  logic             BubbleEXE;
  logic             FlushIF;
  logic             FlushID;
  logic             Halted;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output ID_IR, EXE_IR, MEM_IR, IsBranchTaken, MemBusy,
    input  StallIF, StallID, IsStall, BubbleEXE, FlushIF, FlushID, Halted,
           StallCount
  );

  modport slave (
    input  ID_IR, EXE_IR, MEM_IR, IsBranchTaken, MemBusy,
    output StallIF, StallID, IsStall, BubbleEXE, FlushIF, FlushID, Halted,
           StallCount
  );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Pipeline sequencer for the MyProc2 five-stage core. Detects RAW
//            hazards between ID and EXE/MEM writers (no forwarding), freezes
//            the pipe while data memory is busy, runs the post-branch flush
//            sequence and latches the halted state.
// Ports    : clk  - clock, rising edge
//            rst  - synchronous active-high reset
//            bus  - pipe_ctrl_if.slave: instruction registers, branch/busy
//                   inputs, stall/flush/bubble controls, Halted, StallCount
// Params   : FLUSH_CYCLES - flush length after a taken branch (1..7)
//            CNT_W        - stall counter width (must match bus CNT_W)
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  // Opcode map (IR[31:26])
  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_XOR  = 6'd5;
  localparam logic [5:0] OP_SLL  = 6'd6;
  localparam logic [5:0] OP_SRL  = 6'd7;
  localparam logic [5:0] OP_SRA  = 6'd8;
  localparam logic [5:0] OP_SLLV = 6'd9;
  localparam logic [5:0] OP_SRLV = 6'd10;
  localparam logic [5:0] OP_JALR = 6'd11;
  localparam logic [5:0] OP_ADDI = 6'd12;
  localparam logic [5:0] OP_ANDI = 6'd13;
  localparam logic [5:0] OP_ORI  = 6'd14;
  localparam logic [5:0] OP_LUI  = 6'd15;
  localparam logic [5:0] OP_LW   = 6'd16;
  localparam logic [5:0] OP_LH   = 6'd17;
  localparam logic [5:0] OP_LD   = 6'd18;
  localparam logic [5:0] OP_SW   = 6'd19;
  localparam logic [5:0] OP_SH   = 6'd20;
  localparam logic [5:0] OP_SD   = 6'd21;
  localparam logic [5:0] OP_J    = 6'd24;
  localparam logic [5:0] OP_JAL  = 6'd25;
  localparam logic [5:0] OP_HALT = 6'd63;

  localparam logic [2:0] C_FLUSH    = 3'(FLUSH_CYCLES);
  localparam logic [2:0] C_FLUSH_M1 = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_FLUSH   = 2'd1,
    S_MEMWAIT = 2'd2,
    S_HALTED  = 2'd3
  } state_t;

  // Destination register; 0 doubles as "no destination" since r0 never
  // creates a hazard.
  function automatic logic [4:0] dest_reg(input logic [31:0] ir);
    logic [4:0] d;
    d = 5'd0;
    case (ir[31:26])
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
      OP_SLLV, OP_SRLV, OP_JALR:                    d = ir[15:11];
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI,
      OP_LW, OP_LH, OP_LD:                          d = ir[20:16];
      OP_JAL:                                       d = 5'd31;
      default:                                      d = 5'd0;
    endcase
    return d;
  endfunction

  function automatic logic uses_rs(input logic [5:0] op);
    return !(op inside {OP_LUI, OP_J, OP_JAL, OP_NOP, OP_HALT});
  endfunction

  function automatic logic uses_rt(input logic [5:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL,
                      OP_SRA, OP_SLLV, OP_SRLV, OP_SW, OP_SH, OP_SD};
  endfunction

  function automatic logic src_hit(input logic [4:0] src, input logic [4:0] dst);
    return (dst != 5'd0) && (src == dst);
  endfunction

  // Registered state
  state_t           r_state;
  state_t           r_saved;     // state to resume after MEMWAIT
  logic [2:0]       r_cnt;       // flush cycles left, including the current one
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_halted;

  // Combinational
  state_t     w_eff;
  state_t     w_next;
  state_t     w_saved_nx;
  logic [2:0] w_cnt_nx;
  logic       w_stall_if, w_stall_id, w_is_stall, w_bubble, w_flush;
  logic       w_hazard, w_halt_exe;
  logic [5:0] w_id_op;
  logic [4:0] w_id_rs, w_id_rt, w_exe_dst, w_mem_dst;
  logic       w_unused_bits;

  assign w_id_op    = bus.ID_IR[31:26];
  assign w_id_rs    = bus.ID_IR[25:21];
  assign w_id_rt    = bus.ID_IR[20:16];
  assign w_exe_dst  = dest_reg(bus.EXE_IR[31:0]);
  assign w_mem_dst  = dest_reg(bus.MEM_IR[31:0]);
  assign w_halt_exe = (bus.EXE_IR[31:26] == OP_HALT);

  assign w_hazard =
      (uses_rs(w_id_op) && (src_hit(w_id_rs, w_exe_dst) || src_hit(w_id_rs, w_mem_dst))) ||
      (uses_rt(w_id_op) && (src_hit(w_id_rt, w_exe_dst) || src_hit(w_id_rt, w_mem_dst)));

  assign w_unused_bits = ^{bus.ID_IR[10:0], bus.EXE_IR[25:21], bus.EXE_IR[10:0],
                           bus.MEM_IR[25:21], bus.MEM_IR[10:0]};

  // Once MemBusy has dropped, MEMWAIT behaves exactly like the state it saved,
  // so the resumed sequence starts in the very cycle memory becomes ready.
  assign w_eff = (r_state == S_MEMWAIT) ? r_saved : r_state;

  always_comb begin
    w_next     = r_state;
    w_saved_nx = r_saved;
    w_cnt_nx   = r_cnt;
    w_stall_if = 1'b0;
    w_stall_id = 1'b0;
    w_is_stall = 1'b0;
    w_bubble   = 1'b0;
    w_flush    = 1'b0;

    if (rst) begin
      w_flush = 1'b1;
    end else if (r_state == S_HALTED) begin
      w_stall_if = 1'b1;
      w_stall_id = 1'b1;
      w_is_stall = 1'b1;
    end else if (bus.MemBusy) begin
      w_stall_if = 1'b1;
      w_stall_id = 1'b1;
      w_is_stall = 1'b1;
      w_next     = S_MEMWAIT;
      if (bus.IsBranchTaken) begin
        // The branch cycle produced no flush, so the full sequence is pending.
        w_saved_nx = S_FLUSH;
        w_cnt_nx   = C_FLUSH;
      end else begin
        w_saved_nx = w_eff;
      end
    end else if (w_halt_exe) begin
      // A concurrent branch is ignored; an ongoing flush still covers this cycle.
      w_next   = S_HALTED;
      w_cnt_nx = 3'd0;
      if (w_eff == S_FLUSH) begin
        w_flush = 1'b1;
      end else if (w_hazard) begin
        w_stall_if = 1'b1;
        w_stall_id = 1'b1;
        w_bubble   = 1'b1;
      end
    end else if (bus.IsBranchTaken) begin
      // This cycle is the first flush cycle.
      w_flush = 1'b1;
      if (C_FLUSH_M1 == 3'd0) begin
        w_next   = S_RUN;
        w_cnt_nx = 3'd0;
      end else begin
        w_next   = S_FLUSH;
        w_cnt_nx = C_FLUSH_M1;
      end
    end else if (w_eff == S_FLUSH) begin
      // Hazard check suppressed: ID holds wrong-path garbage.
      w_flush = 1'b1;
      if (r_cnt <= 3'd1) begin
        w_next   = S_RUN;
        w_cnt_nx = 3'd0;
      end else begin
        w_next   = S_FLUSH;
        w_cnt_nx = r_cnt - 3'd1;
      end
    end else begin
      w_next = S_RUN;
      if (w_hazard) begin
        w_stall_if = 1'b1;
        w_stall_id = 1'b1;
        w_bubble   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_saved     <= S_RUN;
      r_cnt       <= 3'd0;
      r_stall_cnt <= '0;
      r_halted    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_saved  <= w_saved_nx;
      r_cnt    <= w_cnt_nx;
      r_halted <= (w_next == S_HALTED);
      if (w_stall_if && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign bus.StallIF    = w_stall_if;
  assign bus.StallID    = w_stall_id;
  assign bus.IsStall    = w_is_stall;
  assign bus.BubbleEXE  = w_bubble;
  assign bus.FlushIF    = w_flush;
  assign bus.FlushID    = w_flush;
  assign bus.Halted     = r_halted & ~rst;
  assign bus.StallCount = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Self-checking bench for pipe_ctrl. A driver applies one input
//            vector per cycle and pushes the reference model's expectation
//            into a scoreboard; a monitor pops and compares every cycle.
//            A second instance with a 4-bit StallCount shares the inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  localparam int FC = 2;

  localparam logic [5:0] OP_NOP  = 6'd0,  OP_ADD  = 6'd1,  OP_SUB  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3,  OP_OR   = 6'd4,  OP_XOR  = 6'd5;
  localparam logic [5:0] OP_SLL  = 6'd6,  OP_SRL  = 6'd7,  OP_SRA  = 6'd8;
  localparam logic [5:0] OP_SLLV = 6'd9,  OP_SRLV = 6'd10, OP_JALR = 6'd11;
  localparam logic [5:0] OP_ADDI = 6'd12, OP_ANDI = 6'd13, OP_ORI  = 6'd14;
  localparam logic [5:0] OP_LUI  = 6'd15, OP_LW   = 6'd16, OP_LH   = 6'd17;
  localparam logic [5:0] OP_LD   = 6'd18, OP_SW   = 6'd19, OP_SH   = 6'd20;
  localparam logic [5:0] OP_SD   = 6'd21, OP_BEQ  = 6'd22, OP_BNE  = 6'd23;
  localparam logic [5:0] OP_J    = 6'd24, OP_JAL  = 6'd25, OP_HALT = 6'd63;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.WIDTH(32), .CNT_W(32)) bus ();
  pipe_ctrl_if #(.WIDTH(32), .CNT_W(4))  bus4 ();

  assign bus4.ID_IR         = bus.ID_IR;
  assign bus4.EXE_IR        = bus.EXE_IR;
  assign bus4.MEM_IR        = bus.MEM_IR;
  assign bus4.IsBranchTaken = bus.IsBranchTaken;
  assign bus4.MemBusy       = bus.MemBusy;

  pipe_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(32)) dut  (.clk(clk), .rst(rst), .bus(bus));
  pipe_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

  typedef struct {
    logic [6:0]  ctl;   // StallIF,StallID,IsStall,BubbleEXE,FlushIF,FlushID,Halted
    logic [31:0] cnt;
    logic [3:0]  cnt4;
    bit          cnt_known;
  } exp_t;

  exp_t sbq[$];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int    m_flush_left = 0;  // flush cycles still owed
  bit    m_halted     = 1'b0;
  longint m_cnt       = 0;
  bit    m_cnt_known  = 1'b0;

  logic [5:0] ops [24] = '{OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL,
                           OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_JALR, OP_ADDI,
                           OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_LH, OP_LD, OP_SW,
                           OP_SH, OP_SD, OP_BEQ, OP_JAL};

  function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'($urandom)};
  endfunction

  function automatic logic [31:0] rnd_ins();
    return ins(ops[$urandom_range(0, 23)], 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
  endfunction

  // Register written by an instruction, or -1 when it writes nothing useful.
  function automatic int writes(input logic [31:0] ir);
    int d;
    case (ir[31:26])
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
      OP_SLLV, OP_SRLV, OP_JALR: d = int'(ir[15:11]);
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_LH, OP_LD: d = int'(ir[20:16]);
      OP_JAL: d = 31;
      default: d = -1;
    endcase
    return (d == 0) ? -1 : d;
  endfunction

  function automatic bit raw(input logic [31:0] id, input logic [31:0] exe,
                             input logic [31:0] mem);
    int  srcs[$];
    logic [5:0] op;
    op = id[31:26];
    if (!(op inside {OP_LUI, OP_J, OP_JAL, OP_NOP, OP_HALT})) srcs.push_back(int'(id[25:21]));
    if (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
                   OP_SLLV, OP_SRLV, OP_SW, OP_SH, OP_SD}) srcs.push_back(int'(id[20:16]));
    foreach (srcs[k]) begin
      if (srcs[k] == writes(exe) || srcs[k] == writes(mem)) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Apply one cycle of inputs and record what the DUT must show during it.
  task automatic step(input logic r, input logic [31:0] id, input logic [31:0] exe,
                      input logic [31:0] mem, input logic br, input logic busy);
    exp_t e;
    logic sif, sid, ist, bub, fl, hlt;
    bit   halt_now;
    @(posedge clk);
    #1;
    rst               = r;
    bus.ID_IR         = id;
    bus.EXE_IR        = exe;
    bus.MEM_IR        = mem;
    bus.IsBranchTaken = br;
    bus.MemBusy       = busy;

    e.cnt       = 32'(m_cnt);
    e.cnt4      = (m_cnt > 15) ? 4'd15 : 4'(m_cnt);
    e.cnt_known = m_cnt_known;
    hlt = m_halted && !r;
    {sif, sid, ist, bub, fl} = '0;

    if (r) begin
      fl = 1'b1;
      m_halted = 1'b0; m_flush_left = 0; m_cnt = 0; m_cnt_known = 1'b1;
    end else if (m_halted) begin
      sif = 1'b1; sid = 1'b1; ist = 1'b1;
    end else if (busy) begin
      sif = 1'b1; sid = 1'b1; ist = 1'b1;
      if (br) m_flush_left = FC;
    end else begin
      halt_now = (exe[31:26] == OP_HALT);
      if (br && !halt_now) m_flush_left = FC;
      if (m_flush_left > 0) begin
        fl = 1'b1;
        m_flush_left--;
      end else if (raw(id, exe, mem)) begin
        sif = 1'b1; sid = 1'b1; bub = 1'b1;
      end
      if (halt_now) begin
        m_halted = 1'b1;
        m_flush_left = 0;
      end
    end
    if (!r && sif) m_cnt++;
    e.ctl = {sif, sid, ist, bub, fl, fl, hlt};
    sbq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: the DUT presents a full control word every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("StallIF",   32'(bus.StallIF),   32'(e.ctl[6]));
        chk("StallID",   32'(bus.StallID),   32'(e.ctl[5]));
        chk("IsStall",   32'(bus.IsStall),   32'(e.ctl[4]));
        chk("BubbleEXE", 32'(bus.BubbleEXE), 32'(e.ctl[3]));
        chk("FlushIF",   32'(bus.FlushIF),   32'(e.ctl[2]));
        chk("FlushID",   32'(bus.FlushID),   32'(e.ctl[1]));
        chk("Halted",    32'(bus.Halted),    32'(e.ctl[0]));
        chk("Halted4",   32'(bus4.Halted),   32'(e.ctl[0]));
        if (e.cnt_known) begin
          chk("StallCount",   bus.StallCount,        e.cnt);
          chk("StallCount_w4", 32'(bus4.StallCount), 32'(e.cnt4));
        end
      end
    end
  end

  localparam logic [31:0] NOP = 32'd0;

  initial begin
    bus.ID_IR = '0; bus.EXE_IR = '0; bus.MEM_IR = '0;
    bus.IsBranchTaken = 1'b0; bus.MemBusy = 1'b0;

    // Reset held two cycles with noisy inputs
    repeat (2) step(1'b1, rnd_ins(), rnd_ins(), rnd_ins(), 1'($urandom), 1'($urandom));

    // Independent ADDs: no stalls
    for (int i = 0; i < 4; i++)
      step(1'b0, ins(OP_ADD, 5'd1, 5'd2, 5'd3), ins(OP_ADD, 5'd4, 5'd5, 5'd6),
           ins(OP_ADD, 5'd7, 5'd8, 5'd9), 1'b0, 1'b0);

    // ADD r3 then dependent SUB: stall while writer in EXE, then in MEM
    step(1'b0, ins(OP_SUB, 5'd3, 5'd5, 5'd4), ins(OP_ADD, 5'd1, 5'd2, 5'd3), NOP, 1'b0, 1'b0);
    step(1'b0, ins(OP_SUB, 5'd3, 5'd5, 5'd4), NOP, ins(OP_ADD, 5'd1, 5'd2, 5'd3), 1'b0, 1'b0);
    step(1'b0, ins(OP_SUB, 5'd3, 5'd5, 5'd4), NOP, NOP, 1'b0, 1'b0);

    // Load-use: LW r6 then SW using r6 as rt
    step(1'b0, ins(OP_SW, 5'd1, 5'd6, 5'd0), ins(OP_LW, 5'd2, 5'd6, 5'd0), NOP, 1'b0, 1'b0);
    step(1'b0, ins(OP_SW, 5'd1, 5'd6, 5'd0), NOP, ins(OP_LW, 5'd2, 5'd6, 5'd0), 1'b0, 1'b0);

    // r0 destination never stalls
    step(1'b0, ins(OP_ADD, 5'd0, 5'd0, 5'd1), ins(OP_ADD, 5'd1, 5'd2, 5'd0),
         ins(OP_ADDI, 5'd1, 5'd0, 5'd0), 1'b0, 1'b0);

    // Taken branch: exactly FC flush cycles, then a second pulse on cycle 2
    step(1'b0, rnd_ins(), ins(OP_BEQ, 5'd1, 5'd2, 5'd0), NOP, 1'b1, 1'b0);
    repeat (3) step(1'b0, NOP, NOP, NOP, 1'b0, 1'b0);
    step(1'b0, rnd_ins(), NOP, NOP, 1'b1, 1'b0);
    step(1'b0, rnd_ins(), NOP, NOP, 1'b1, 1'b0);
    repeat (3) step(1'b0, NOP, NOP, NOP, 1'b0, 1'b0);

    // MemBusy for 3 cycles on the last flush cycle
    step(1'b0, NOP, NOP, NOP, 1'b1, 1'b0);
    repeat (3) step(1'b0, NOP, NOP, NOP, 1'b0, 1'b1);
    repeat (2) step(1'b0, NOP, NOP, NOP, 1'b0, 1'b0);

    // MemBusy together with a branch: flush deferred until memory is ready
    step(1'b0, NOP, NOP, NOP, 1'b1, 1'b1);
    step(1'b0, NOP, NOP, NOP, 1'b0, 1'b1);
    repeat (3) step(1'b0, NOP, NOP, NOP, 1'b0, 1'b0);

    // HALT together with a branch: halt wins, held with random inputs
    step(1'b0, rnd_ins(), ins(OP_HALT, 5'd0, 5'd0, 5'd0), NOP, 1'b1, 1'b0);
    repeat (12) step(1'b0, rnd_ins(), rnd_ins(), rnd_ins(), 1'($urandom), 1'($urandom));
    step(1'b1, NOP, NOP, NOP, 1'b0, 1'b0);
    repeat (2) step(1'b0, NOP, NOP, NOP, 1'b0, 1'b0);

    // 20 stall cycles: 4-bit counter saturates at 15
    repeat (20) step(1'b0, NOP, NOP, NOP, 1'b0, 1'b1);
    repeat (2) step(1'b0, NOP, NOP, NOP, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      logic [31:0] exe;
      exe = ($urandom_range(0, 99) == 0) ? ins(OP_HALT, 5'd0, 5'd0, 5'd0) : rnd_ins();
      step(($urandom_range(0, 59) == 0), rnd_ins(), exe, rnd_ins(),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
    end

    repeat (3) @(posedge clk);
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
